// File: rtl/alu_issue_ctrl_if.sv
// ALU opcode package and the bundled decode / ALU / write-back bus of the issue controller.
// The master modport is the controller's view; slave is the surrounding decode/ALU/regfile view.
package core_pkg;
  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_XOR  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_AND  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLTS = 4'd8,
    ALU_SLTU = 4'd9
  } alu_opcode_e;
endpackage

interface alu_issue_ctrl_if #(parameter int REG_AW = 5);
  import core_pkg::*;

  logic              dec_valid_ip;
  logic              dec_ready_op;
  alu_opcode_e       dec_operator_ip;
  logic [REG_AW-1:0] dec_rs1_addr_ip;
  logic [REG_AW-1:0] dec_rs2_addr_ip;
  logic [REG_AW-1:0] dec_rd_addr_ip;
  logic [31:0]       dec_rs1_data_ip;
  logic [31:0]       dec_rs2_data_ip;
  logic [31:0]       dec_imm_ip;
  logic              dec_use_imm_ip;
  logic              alu_enable_op;
  alu_opcode_e       alu_operator_op;
  logic [31:0]       alu_operand_a_op;
  logic [31:0]       alu_operand_b_op;
  logic [31:0]       alu_result_ip;
  logic              alu_valid_ip;
  logic              wb_valid_op;
  logic              wb_ready_ip;
  logic [REG_AW-1:0] wb_rd_addr_op;
  logic [31:0]       wb_data_op;
  logic              err_timeout_op;
  logic [31:0]       retired_cnt_op;

  modport master (
    input  dec_valid_ip, dec_operator_ip, dec_rs1_addr_ip, dec_rs2_addr_ip, dec_rd_addr_ip,
           dec_rs1_data_ip, dec_rs2_data_ip, dec_imm_ip, dec_use_imm_ip,
           alu_result_ip, alu_valid_ip, wb_ready_ip,
    output dec_ready_op, alu_enable_op, alu_operator_op, alu_operand_a_op, alu_operand_b_op,
           wb_valid_op, wb_rd_addr_op, wb_data_op, err_timeout_op, retired_cnt_op
  );

  modport slave (
    output dec_valid_ip, dec_operator_ip, dec_rs1_addr_ip, dec_rs2_addr_ip, dec_rd_addr_ip,
           dec_rs1_data_ip, dec_rs2_data_ip, dec_imm_ip, dec_use_imm_ip,
           alu_result_ip, alu_valid_ip, wb_ready_ip,
    input  dec_ready_op, alu_enable_op, alu_operator_op, alu_operand_a_op, alu_operand_b_op,
           wb_valid_op, wb_rd_addr_op, wb_data_op, err_timeout_op, retired_cnt_op
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Issue controller: takes one decoded instruction, holds the ALU request until the result
// arrives (or times out), then offers the result on the write-back port.
module alu_issue_ctrl
  import core_pkg::*;
#(
  parameter int TIMEOUT_CYC = 16,
  parameter int REG_AW      = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  alu_issue_ctrl_if.master     bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] WB   = 2'd2;

  logic [1:0]        state_q;
  logic [7:0]        cnt_q;
  logic              err_q;
  logic [31:0]       retired_cnt_q;

  alu_opcode_e       op_p0;
  logic [31:0]       opa_p0;
  logic [31:0]       opb_p0;
  logic [REG_AW-1:0] rd_p0;
  logic [REG_AW-1:0] wb_rd_p1;
  logic [31:0]       wb_data_p1;

  logic              dec_ready;
  logic              accept;
  logic              wb_hs;
  logic              fwd_a;
  logic              fwd_b;
  logic [31:0]       src_a;
  logic [31:0]       src_b;

  // Ready is masked by reset so nothing is accepted while the block is held in reset.
  assign dec_ready = reset && ((state_q == IDLE) || ((state_q == WB) && bus.wb_ready_ip));
  assign accept    = bus.dec_valid_ip && dec_ready;
  assign wb_hs     = (state_q == WB) && bus.wb_ready_ip;

  // The result retiring this cycle has not reached the register file yet, so bypass it; x0 is hardwired.
  assign fwd_a = wb_hs && (bus.dec_rs1_addr_ip == wb_rd_p1) && (bus.dec_rs1_addr_ip != '0);
  assign fwd_b = wb_hs && (bus.dec_rs2_addr_ip == wb_rd_p1) && (bus.dec_rs2_addr_ip != '0);
  assign src_a = fwd_a ? wb_data_p1 : bus.dec_rs1_data_ip;
  assign src_b = bus.dec_use_imm_ip ? bus.dec_imm_ip : (fwd_b ? wb_data_p1 : bus.dec_rs2_data_ip);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      err_q         <= 1'b0;
      retired_cnt_q <= '0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        IDLE: if (accept) state_q <= EXEC;
        EXEC: begin
          if (bus.alu_valid_ip) begin
            state_q <= WB;
          end else if (cnt_q == 8'(TIMEOUT_CYC - 1)) begin
            state_q <= IDLE;
            err_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        WB:      if (wb_hs) state_q <= accept ? EXEC : IDLE;
        default: state_q <= IDLE;
      endcase
      if (accept) cnt_q <= '0;
      if (wb_hs) retired_cnt_q <= retired_cnt_q + 32'd1;
    end
  end

  // Issue stage: operands and destination captured at accept.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_p0  <= ALU_ADD;
      opa_p0 <= '0;
      opb_p0 <= '0;
      rd_p0  <= '0;
    end else if (accept) begin
      op_p0  <= bus.dec_operator_ip;
      opa_p0 <= src_a;
      opb_p0 <= src_b;
      rd_p0  <= bus.dec_rd_addr_ip;
    end
  end

  // Write-back stage: result captured when the ALU answers during EXEC.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wb_rd_p1   <= '0;
      wb_data_p1 <= '0;
    end else if ((state_q == EXEC) && bus.alu_valid_ip) begin
      wb_rd_p1   <= rd_p0;
      wb_data_p1 <= bus.alu_result_ip;
    end
  end

  assign bus.dec_ready_op     = dec_ready;
  assign bus.alu_enable_op    = (state_q == EXEC);
  assign bus.alu_operator_op  = op_p0;
  assign bus.alu_operand_a_op = opa_p0;
  assign bus.alu_operand_b_op = opb_p0;
  assign bus.wb_valid_op      = (state_q == WB);
  assign bus.wb_rd_addr_op    = wb_rd_p1;
  assign bus.wb_data_op       = wb_data_p1;
  assign bus.err_timeout_op   = err_q;
  assign bus.retired_cnt_op   = retired_cnt_q;

endmodule

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

Decode-side issue controller driving the ALU's request interface: accepts one decoded instruction at a time via valid/ready, registers operands (immediate select and same-cycle write-back forwarding), holds the ALU request until the ALU returns valid, then presents the result on a valid/ready write-back port to the register file. Sits between decode and the ALU/register-file write port. Includes a response timeout and a retired-instruction counter.

## Interface
- TIMEOUT_CYC, 16, max EXEC cycles without alu_valid before abort; legal range 1..255
- REG_AW, 5, register address width
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- dec_valid_ip  in  1  decoded instruction valid
- dec_ready_op  out  1  controller can accept instruction
- dec_operator_ip  in  alu_opcode_e (CORE_PKG)  operation
- dec_rs1_addr_ip, dec_rs2_addr_ip, dec_rd_addr_ip  in  REG_AW each  source/destination registers
- dec_rs1_data_ip, dec_rs2_data_ip  in  32  register-file read data
- dec_imm_ip  in  32  sign-extended immediate
- dec_use_imm_ip  in  1  operand b = immediate when 1
- alu_enable_op  out  1  ALU request
- alu_operator_op  out  alu_opcode_e  registered operator
- alu_operand_a_op, alu_operand_b_op  out  32 each  registered operands
- alu_result_ip  in  32  ALU result
- alu_valid_ip  in  1  ALU result valid
- wb_valid_op  out  1  write-back valid
- wb_ready_ip  in  1  register file accepts write-back
- wb_rd_addr_op  out  REG_AW  destination register
- wb_data_op  out  32  result data
- err_timeout_op  out  1  one-cycle pulse on ALU timeout
- retired_cnt_op  out  32  count of completed write-back handshakes

## Operation
- States: IDLE, EXEC, WB. Reset state IDLE.
- dec_ready_op = (state==IDLE) or (state==WB and wb_ready_ip); forced 0 while reset low.
- Accept = dec_valid_ip and dec_ready_op. On accept: latch operator, rd, operand a = fwd(rs1), operand b = dec_use_imm_ip ? dec_imm_ip : fwd(rs2); next state EXEC; timeout counter cleared.
- fwd(rsX): if WB handshake occurs in the same cycle, rsX == wb_rd_addr_op and rsX != 0 → wb_data_op; else dec_rsX_data_ip. Register x0 never forwarded.
- EXEC: alu_enable_op=1. If alu_valid_ip: capture alu_result_ip into wb_data_op, next WB. Else counter increments; when counter reaches TIMEOUT_CYC-1 with no valid: err_timeout_op=1 for the next cycle, state → IDLE, instruction dropped, no write-back.
- WB: wb_valid_op=1, wb_rd_addr_op/wb_data_op stable until wb_ready_ip. On handshake: retired_cnt_op+1 (wraps 0xFFFFFFFF→0), next EXEC if new accept same cycle, else IDLE. rd=0 still written back (register file discards).
- alu_enable_op=0 outside EXEC; alu_operator_op/operands hold last latched values.
- Unsupported operator: ALU gives no valid → timeout path.

## Timing
- Reset (async assert): state IDLE, alu_enable_op 0, alu_operator_op ALU_ADD, operands 0, wb_valid_op 0, wb_rd_addr_op 0, wb_data_op 0, err_timeout_op 0, retired_cnt_op 0, counter 0. Mid-operation reset drops any in-flight instruction, no write-back.
- Accept at edge N → alu_enable_op high cycle N+1; with same-cycle alu_valid, wb_valid_op high cycle N+2. Back-to-back throughput: one instruction per 2 cycles (WB handshake overlapped with next accept).
- Timeout: accept at edge N, enable high cycles N+1..N+TIMEOUT_CYC, err_timeout_op high cycle N+TIMEOUT_CYC+1, dec_ready_op high same cycle.
- wb_ready_ip low holds WB indefinitely; dec_ready_op stays 0; no timeout in WB.
- alu_valid_ip outside EXEC ignored.

## Test plan
- Reset release, ADD a=5 imm=7 (use_imm=1), ALU returns 12 same cycle, wb_ready=1 → wb_valid two cycles after accept, rd/data=12, retired_cnt 1.
- Back-to-back: SUB rd=3 result 10 in WB with wb_ready=1, next instr rs1=3 (dec data stale 0) accepted same cycle → alu_operand_a_op=10; repeat with rs1=0 → no forwarding, operand 0.
- Backpressure: wb_ready low 5 cycles → wb_valid/data stable, dec_ready 0; release → handshake, retired_cnt increments once.
- Timeout TIMEOUT_CYC=4, alu_valid never asserted → enable high 4 cycles, err pulse 1 cycle, back to IDLE, no wb_valid, retired_cnt unchanged.
- SLTS a=-3 b=2 via rs2 (use_imm=0), ALU returns 1 → wb_data 1; alu_valid asserted during IDLE → ignored.
- Reset asserted during EXEC and during WB → all outputs to reset values immediately; retired_cnt preloaded near 0xFFFFFFFF wraps to 0 on next handshake.
